// File: rtl/mod12_load_arbiter_if.sv
// Bundle of the two requester handshakes, the counter load port and the
// busy flag shared between the arbiter and its surroundings.
interface mod12_load_arbiter_if;
  logic       req0;
  logic [3:0] val0;
  logic       ack0;
  logic       err0;
  logic       req1;
  logic [3:0] val1;
  logic       ack1;
  logic       err1;
  logic [3:0] count;
  logic       load;
  logic [3:0] d_out;
  logic       busy;

  // Requesters plus counter: they drive requests, values and count.
  modport master (
    output req0, val0, req1, val1, count,
    input  ack0, err0, ack1, err1, load, d_out, busy
  );

  // Arbiter side: it consumes requests and count, drives everything else.
  modport slave (
    input  req0, val0, req1, val1, count,
    output ack0, err0, ack1, err1, load, d_out, busy
  );
endinterface

// File: rtl/mod12_load_arbiter.sv
// Round-robin arbiter sharing the synchronous load port of a mod-12
// up counter between two requesters. Each granted value is loaded,
// retried when the 11->0 wrap swallows the load, and confirmed by
// reading count back before acknowledging.
module mod12_load_arbiter #(
  parameter int RETRY_MAX = 2
) (
  input logic                 clk,
  input logic                 rst,
  mod12_load_arbiter_if.slave bus
);

  localparam int RW = $clog2(RETRY_MAX + 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    VERIFY = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state, state_n;
  logic          ptr, ptr_n;
  logic          idx, idx_n;
  logic [3:0]    v, v_n;
  logic [RW-1:0] retry, retry_n;
  logic [RW-1:0] retry_inc;

  logic          win;
  logic [3:0]    win_val;

  logic          load_q, load_n;
  logic [3:0]    d_out_q, d_out_n;
  logic          ack_n, err_n;
  logic          ack0_q, err0_q, ack1_q, err1_q;
  logic          busy_q;

  // Pick the winner of the current requests and the saturating retry increment.
  always_comb begin
    win       = 1'b0;
    win_val   = bus.val0;
    retry_inc = retry;
    if (bus.req0 && bus.req1) begin
      win = ptr;
    end else begin
      win = bus.req1;
    end
    win_val = win ? bus.val1 : bus.val0;
    if (retry != RETRY_LIM) begin
      retry_inc = retry + 1'b1;
    end
  end

  // Next-state and next-output logic for the grant/issue/verify/respond flow.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = idx;
    v_n     = v;
    retry_n = retry;
    load_n  = 1'b0;
    d_out_n = d_out_q;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          idx_n = win;
          v_n   = win_val;
          ptr_n = ~win;
          if (win_val >= 4'd12) begin
            state_n = RESP;
            err_n   = 1'b1;
          end else begin
            state_n = ISSUE;
            load_n  = 1'b1;
            d_out_n = win_val;
            retry_n = '0;
          end
        end
      end
      ISSUE: begin
        if (bus.count == 4'd11) begin
          retry_n = retry_inc;
          if (retry_inc == RETRY_LIM) begin
            state_n = RESP;
            err_n   = 1'b1;
          end else begin
            load_n = 1'b1;
          end
        end else begin
          state_n = VERIFY;
        end
      end
      VERIFY: begin
        state_n = RESP;
        if (bus.count == v) begin
          ack_n = 1'b1;
        end else begin
          err_n = 1'b1;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Register state, bookkeeping and every output; rst drops any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      idx     <= 1'b0;
      v       <= 4'd0;
      retry   <= '0;
      load_q  <= 1'b0;
      d_out_q <= 4'd0;
      ack0_q  <= 1'b0;
      err0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      idx     <= idx_n;
      v       <= v_n;
      retry   <= retry_n;
      load_q  <= load_n;
      d_out_q <= d_out_n;
      ack0_q  <= ack_n & ~idx_n;
      err0_q  <= err_n & ~idx_n;
      ack1_q  <= ack_n & idx_n;
      err1_q  <= err_n & idx_n;
      busy_q  <= (state_n != IDLE);
    end
  end

  assign bus.load  = load_q;
  assign bus.d_out = d_out_q;
  assign bus.ack0  = ack0_q;
  assign bus.err0  = err0_q;
  assign bus.ack1  = ack1_q;
  assign bus.err1  = err1_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mod12_load_arbiter.sv
// Directed bench for mod12_load_arbiter: two arbiter instances
// (RETRY_MAX 2 and 1), each driving its own mod-12 counter model.
module tb_mod12_load_arbiter;
  logic clk;
  logic rst;
  logic disturb;
  int   total;
  int   bad;
  int   n;
  logic exp_idx;

  mod12_load_arbiter_if bus ();
  mod12_load_arbiter_if bus1 ();

  mod12_load_arbiter #(.RETRY_MAX(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  mod12_load_arbiter #(.RETRY_MAX(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter model for dut: the 11->0 wrap beats load; disturb bumps it by 2.
  always @(posedge clk) begin
    if (rst) bus.count <= 4'd0;
    else if (bus.count == 4'd11) bus.count <= 4'd0;
    else if (disturb) bus.count <= bus.count + 4'd2;
    else if (bus.load) bus.count <= bus.d_out;
    else bus.count <= bus.count + 4'd1;
  end

  // Counter model for dut1.
  always @(posedge clk) begin
    if (rst) bus1.count <= 4'd0;
    else if (bus1.count == 4'd11) bus1.count <= 4'd0;
    else if (bus1.load) bus1.count <= bus1.d_out;
    else bus1.count <= bus1.count + 4'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int which, input logic r0, input logic [3:0] v0,
                               input logic r1, input logic [3:0] v1);
    if (which == 0) begin
      bus.req0 = r0; bus.val0 = v0; bus.req1 = r1; bus.val1 = v1;
    end else begin
      bus1.req0 = r0; bus1.val0 = v0; bus1.req1 = r1; bus1.val1 = v1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCount(input int which, input logic [3:0] target);
    int k;
    k = 0;
    while (((which == 0) ? bus.count : bus1.count) !== target && k < 24) begin
      tick();
      k++;
    end
    checkOutput("wait_count", (which == 0) ? bus.count : bus1.count, target);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    disturb = 1'b0;
    applyStimulus(0, 1'b0, 4'd0, 1'b0, 4'd0);
    applyStimulus(1, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    tick();
    rst = 1'b0;
    $display("[TB] reset state");
    checkOutput("rst_load", bus.load, 1'b0);
    checkOutput("rst_dout", bus.d_out, 4'd0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_acks", {bus.ack0, bus.err0, bus.ack1, bus.err1}, 4'd0);
    checkOutput("rst_count", bus.count, 4'd0);

    $display("[TB] single valid load");
    waitCount(0, 4'd3);
    applyStimulus(0, 1'b1, 4'd7, 1'b0, 4'd0);
    tick();
    checkOutput("s_load_e0", bus.load, 1'b1);
    checkOutput("s_dout_e0", bus.d_out, 4'd7);
    checkOutput("s_busy_e0", bus.busy, 1'b1);
    checkOutput("s_ack_e0", bus.ack0, 1'b0);
    tick();
    checkOutput("s_load_e1", bus.load, 1'b0);
    checkOutput("s_count_e1", bus.count, 4'd7);
    checkOutput("s_busy_e1", bus.busy, 1'b1);
    tick();
    checkOutput("s_resp_e2", {bus.ack0, bus.err0, bus.ack1, bus.err1}, 4'b1000);
    applyStimulus(0, 1'b0, 4'd7, 1'b0, 4'd0);
    tick();
    checkOutput("s_ack_e3", bus.ack0, 1'b0);
    checkOutput("s_busy_e3", bus.busy, 1'b0);

    $display("[TB] round robin");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(0, 1'b1, 4'd2, 1'b1, 4'd9);
    for (int g = 0; g < 4; g++) begin
      exp_idx = g[0];
      n = 0;
      do begin
        tick();
        n++;
      end while (!(bus.ack0 || bus.ack1) && n < 20);
      checkOutput("rr_ack0", bus.ack0, !exp_idx);
      checkOutput("rr_ack1", bus.ack1, exp_idx);
      checkOutput("rr_err", {bus.err0, bus.err1}, 4'd0);
      checkOutput("rr_count", bus.count, exp_idx ? 4'd10 : 4'd3);
      if (g == 3) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
      end else if (!exp_idx) begin
        bus.req0 = 1'b0;
        tick();
        bus.req0 = 1'b1;
      end else begin
        bus.req1 = 1'b0;
        tick();
        bus.req1 = 1'b1;
      end
    end

    $display("[TB] wrap collision");
    waitCount(0, 4'd10);
    applyStimulus(0, 1'b0, 4'd0, 1'b1, 4'd5);
    tick();
    checkOutput("w_load_e0", bus.load, 1'b1);
    checkOutput("w_dout_e0", bus.d_out, 4'd5);
    checkOutput("w_count_e0", bus.count, 4'd11);
    tick();
    checkOutput("w_load_e1", bus.load, 1'b1);
    checkOutput("w_count_e1", bus.count, 4'd0);
    checkOutput("w_ack_e1", bus.ack1, 1'b0);
    tick();
    checkOutput("w_load_e2", bus.load, 1'b0);
    checkOutput("w_count_e2", bus.count, 4'd5);
    checkOutput("w_ack_e2", bus.ack1, 1'b0);
    tick();
    checkOutput("w_resp_e3", {bus.ack0, bus.err0, bus.ack1, bus.err1}, 4'b0010);
    applyStimulus(0, 1'b0, 4'd0, 1'b0, 4'd5);
    tick();
    checkOutput("w_ack_e4", bus.ack1, 1'b0);

    $display("[TB] retry limit");
    waitCount(1, 4'd10);
    applyStimulus(1, 1'b1, 4'd3, 1'b0, 4'd0);
    tick();
    checkOutput("r_load_e0", bus1.load, 1'b1);
    tick();
    checkOutput("r_resp_e1", {bus1.ack0, bus1.err0, bus1.ack1, bus1.err1}, 4'b0100);
    checkOutput("r_load_e1", bus1.load, 1'b0);
    checkOutput("r_count_e1", bus1.count, 4'd0);
    applyStimulus(1, 1'b0, 4'd3, 1'b0, 4'd0);
    tick();
    checkOutput("r_err_e2", bus1.err0, 1'b0);
    checkOutput("r_count_e2", bus1.count, 4'd1);
    checkOutput("r_busy_e2", bus1.busy, 1'b0);

    $display("[TB] invalid values");
    applyStimulus(0, 1'b1, 4'd12, 1'b0, 4'd0);
    tick();
    checkOutput("i12_resp", {bus.ack0, bus.err0, bus.ack1, bus.err1}, 4'b0100);
    checkOutput("i12_load", bus.load, 1'b0);
    checkOutput("i12_busy", bus.busy, 1'b1);
    applyStimulus(0, 1'b0, 4'd12, 1'b0, 4'd0);
    tick();
    checkOutput("i12_err_off", bus.err0, 1'b0);
    checkOutput("i12_idle", bus.busy, 1'b0);
    applyStimulus(0, 1'b1, 4'd15, 1'b1, 4'd12);
    tick();
    checkOutput("iptr1_resp", {bus.ack0, bus.err0, bus.ack1, bus.err1}, 4'b0001);
    checkOutput("iptr1_load", bus.load, 1'b0);
    bus.req1 = 1'b0;
    tick();
    bus.req1 = 1'b1;
    tick();
    checkOutput("iptr0_resp", {bus.ack0, bus.err0, bus.ack1, bus.err1}, 4'b0100);
    checkOutput("iptr0_load", bus.load, 1'b0);
    applyStimulus(0, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();

    $display("[TB] verify mismatch");
    waitCount(0, 4'd1);
    applyStimulus(0, 1'b1, 4'd6, 1'b0, 4'd0);
    tick();
    checkOutput("d_load_e0", bus.load, 1'b1);
    disturb = 1'b1;
    tick();
    disturb = 1'b0;
    checkOutput("d_count_e1", bus.count, 4'd4);
    tick();
    checkOutput("d_resp_e2", {bus.ack0, bus.err0, bus.ack1, bus.err1}, 4'b0100);
    applyStimulus(0, 1'b0, 4'd6, 1'b0, 4'd0);
    tick();

    $display("[TB] reset mid-transaction");
    waitCount(0, 4'd1);
    applyStimulus(0, 1'b1, 4'd8, 1'b0, 4'd0);
    tick();
    checkOutput("m_load_e0", bus.load, 1'b1);
    rst = 1'b1;
    tick();
    checkOutput("m_load_rst", bus.load, 1'b0);
    checkOutput("m_busy_rst", bus.busy, 1'b0);
    checkOutput("m_resp_rst", {bus.ack0, bus.err0, bus.ack1, bus.err1}, 4'd0);
    checkOutput("m_count_rst", bus.count, 4'd0);
    checkOutput("m_dout_rst", bus.d_out, 4'd0);
    rst = 1'b0;
    applyStimulus(0, 1'b0, 4'd8, 1'b1, 4'd4);
    tick();
    checkOutput("m_load_e2", bus.load, 1'b1);
    checkOutput("m_dout_e2", bus.d_out, 4'd4);
    checkOutput("m_resp_e2", {bus.ack0, bus.err0, bus.ack1, bus.err1}, 4'd0);
    tick();
    checkOutput("m_count_e3", bus.count, 4'd4);
    tick();
    checkOutput("m_resp_e4", {bus.ack0, bus.err0, bus.ack1, bus.err1}, 4'b0010);
    applyStimulus(0, 1'b0, 4'd8, 1'b0, 4'd4);
    tick();
    checkOutput("m_busy_e5", bus.busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
